icache_refill_ctrl: RTL
=======================

# icache_refill_ctrl

Miss-handling controller for the 2-way, 256-set, 16-byte-line instruction cache. On a lookup miss it stalls fetch, reads the line from instruction memory as four 32-bit beats over a request/grant/response port, and picks the victim way (invalid-first, else per-set LRU). It then issues a single write into the tag/data arrays. It also sequences a full cache invalidate (flush) and owns the LRU state.

## Interface
- ADDR_W, 64, fetch address width
- INDEX_W, 8, set index bits (256 sets)
- OFFSET_W, 4, line byte offset bits (16 B line)
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- miss_valid  in  1  lookup missed for miss_addr this cycle
- miss_addr  in  ADDR_W  missing fetch address
- way_valid  in  2  valid bits of both ways of miss_addr's set
- hit_valid  in  1  lookup hit this cycle
- hit_index  in  INDEX_W  set of the hit
- hit_way  in  1  way that hit
- flush  in  1  request full invalidate (level, sampled in IDLE)
- stall  out  1  fetch must hold pc
- flush_busy  out  1  invalidate sweep in progress
- mem_req  out  1  beat read request
- mem_addr  out  ADDR_W  beat address (word aligned)
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read data valid (in request order)
- mem_rdata  in  32  read data
- fill_we  out  1  array write strobe
- fill_way_mask  out  2  ways written
- fill_index  out  INDEX_W  set written
- fill_tag  out  ADDR_W-INDEX_W-OFFSET_W  tag written
- fill_valid  out  1  valid bit written
- fill_data  out  128  line data, word k at [32k+31:32k]
- crit_valid  out  1  critical word available (CWF only)
- crit_word  out  32  critical word

## Operation
- States: IDLE, REQ (issuing beats, collecting responses), WRITE (one cycle), FLUSH.
- IDLE: flush=1 → FLUSH (priority over a simultaneous miss_valid). Else miss_valid=1 → capture miss_addr and way_valid, clear counters → REQ.
- REQ: mem_req=1 while req_cnt<4; a beat transfers when mem_req&mem_gnt; req_cnt++. mem_addr = {line_base, beat_word, 2'b00}. It is held stable while mem_req&!mem_gnt. Up to 4 beats are outstanding. Each mem_rvalid stores mem_rdata into word slot (order of issue) and increments rsp_cnt. The 4th response → WRITE. mem_rvalid with no outstanding beat is ignored.
- Victim: way0 if !way_valid[0], else way1 if !way_valid[1], else lru[index].
- WRITE: fill_we=1, fill_way_mask=onehot(victim), fill_valid=1, fill_index/fill_tag from captured addr, fill_data = assembled line. lru[index] <= ~victim. Next state → IDLE (or FLUSH if flush pending).
- LRU: 256×1 bits; hit_valid in any non-FLUSH state sets lru[hit_index] <= ~hit_way. A WRITE to the same set in the same cycle wins.
- FLUSH: counter 0..255; each cycle fill_we=1, fill_way_mask=2'b11, fill_valid=0, fill_index=counter, lru[counter] <= 0. After index 255 → IDLE.
- flush asserted outside IDLE is latched as pending and served after the current refill completes.
- miss_valid/miss_addr are ignored outside IDLE.
- stall = (state==IDLE & (miss_valid|flush)) | state!=IDLE; flush_busy = state==FLUSH.

## Timing
- Reset (rst=0, async): state IDLE, counters 0, pending flush 0, lru all 0. All outputs 0, including fill_data, mem_addr, crit_word.
- Reset mid-refill or mid-flush aborts immediately; the memory side is reset together with this block.
- Miss seen at cycle 0 (stall high combinationally). mem_req from cycle 1. With gnt=1 and 1-cycle rvalid: beats granted cycles 1–4, responses cycles 2–5, fill_we cycle 6, stall low cycle 7.
- Flush: 256 fill_we cycles, stall high for 256 cycles plus the IDLE request cycle.
- fill_we, crit_valid: single-cycle pulses.

## Configuration
- ICACHE_CWF_EN defined: beats are issued starting at miss_addr[3:2] and wrap modulo 4 (e.g. offset 8 → words 2,3,0,1). crit_valid pulses with the first response, and crit_word = that word. Data slots are indexed by word number, so fill_data layout is unchanged.
- Undefined: beats are always issued in order 0,1,2,3; crit_valid and crit_word are constant 0.

## Test plan
- Miss at 0x8000_1234, way_valid=00, gnt=1, rdata=A,B,C,D → mem_addr 0x…1230/34/38/3C. fill_we cycle 6 with way_mask=01, index=0x23, tag=0x80001, data={D,C,B,A}. lru[0x23]=1.
- way_valid=11, lru[0x23]=1 → victim way1, mask=10, lru becomes 0. Hit on way0 of set 0x23 then sets lru=1.
- mem_gnt low for 3 cycles on beat 1 → mem_addr held constant. Line is still correct; fill_we is delayed 3 cycles.
- flush together with miss_valid in IDLE → flush wins, 256 writes with mask 11 and valid 0. The miss is serviced only if re-presented afterward.
- rst pulled low at the 2nd beat → all outputs 0 asynchronously, state IDLE, stall=0 after release.
- ICACHE_CWF_EN, miss at offset 0x8 → request order words 2,3,0,1. crit_valid with word 2 data on the first rvalid; fill_data layout is identical to the non-CWF case.

Source files
------------

// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - I-cache miss refill, victim selection, LRU and flush sequencer
// Optional feature macro: ICACHE_CWF_EN (critical-word-first beat ordering)
module icache_refill_ctrl #(
  parameter int ADDR_W   = 64,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           miss_valid_i,
  input  logic [ADDR_W-1:0]              miss_addr_i,
  input  logic [1:0]                     way_valid_i,
  input  logic                           hit_valid_i,
  input  logic [INDEX_W-1:0]             hit_index_i,
  input  logic                           hit_way_i,
  input  logic                           flush_i,
  output logic                           stall_o,
  output logic                           flush_busy_o,
  output logic                           mem_req_o,
  output logic [ADDR_W-1:0]              mem_addr_o,
  input  logic                           mem_gnt_i,
  input  logic                           mem_rvalid_i,
  input  logic [31:0]                    mem_rdata_i,
  output logic                           fill_we_o,
  output logic [1:0]                     fill_way_mask_o,
  output logic [INDEX_W-1:0]             fill_index_o,
  output logic [ADDR_W-INDEX_W-OFFSET_W-1:0] fill_tag_o,
  output logic                           fill_valid_o,
  output logic [127:0]                   fill_data_o,
  output logic                           crit_valid_o,
  output logic [31:0]                    crit_word_o
);

  localparam int LINE_W = ADDR_W - OFFSET_W;
  localparam int SETS   = 1 << INDEX_W;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WRITE, S_FLUSH} state_e;

  state_e                state_q, state_d;
  logic [LINE_W-1:0]     line_q;
  logic [1:0]            way_valid_q;
  logic [2:0]            req_cnt_q;
  logic [2:0]            rsp_cnt_q;
  logic [1:0]            start_q;
  logic [3:0][31:0]      words_q;
  logic                  flush_pend_q;
  logic [INDEX_W-1:0]    flush_cnt_q;
  logic [SETS-1:0]       lru_q;

  logic [INDEX_W-1:0]    line_index;
  logic                  victim;
  logic                  capture;
  logic                  beat_grant;
  logic                  rsp_take;
  logic [1:0]            req_word;
  logic [1:0]            rsp_word;
  logic                  unused_bits;

  assign line_index = line_q[INDEX_W-1:0];
  assign victim     = !way_valid_q[0] ? 1'b0 : (!way_valid_q[1] ? 1'b1 : lru_q[line_index]);
  assign capture    = (state_q == S_IDLE) && !flush_i && miss_valid_i;
  assign beat_grant = mem_req_o && mem_gnt_i;
  // A response only counts while a granted beat is still waiting for its data
  assign rsp_take   = (state_q == S_REQ) && mem_rvalid_i && (rsp_cnt_q != req_cnt_q);
  // Slots are indexed by word number so the assembled line layout never depends on beat order
  assign req_word   = req_cnt_q[1:0] + start_q;
  assign rsp_word   = rsp_cnt_q[1:0] + start_q;
  assign unused_bits = ^{miss_addr_i[OFFSET_W-3:0]};

`ifdef ICACHE_CWF_EN
  // First response of a refill is the word the fetch stalled on
  assign crit_valid_o = rsp_take && (rsp_cnt_q == 3'd0);
  assign crit_word_o  = crit_valid_o ? mem_rdata_i : 32'd0;
`else
  assign crit_valid_o = 1'b0;
  assign crit_word_o  = 32'd0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and output decode
  always_comb begin
    state_d         = state_q;
    stall_o         = (state_q != S_IDLE);
    flush_busy_o    = (state_q == S_FLUSH);
    mem_req_o       = 1'b0;
    mem_addr_o      = '0;
    fill_we_o       = 1'b0;
    fill_way_mask_o = 2'b00;
    fill_index_o    = '0;
    fill_tag_o      = '0;
    fill_valid_o    = 1'b0;
    fill_data_o     = '0;
    case (state_q)
      S_IDLE: begin
        stall_o = miss_valid_i || flush_i;
        if (flush_i)           state_d = S_FLUSH;
        else if (miss_valid_i) state_d = S_REQ;
      end
      S_REQ: begin
        mem_req_o  = !req_cnt_q[2];
        mem_addr_o = mem_req_o ? {line_q, req_word, 2'b00} : '0;
        if (rsp_take && (rsp_cnt_q == 3'd3)) state_d = S_WRITE;
      end
      S_WRITE: begin
        fill_we_o       = 1'b1;
        fill_way_mask_o = victim ? 2'b10 : 2'b01;
        fill_index_o    = line_index;
        fill_tag_o      = line_q[LINE_W-1:INDEX_W];
        fill_valid_o    = 1'b1;
        fill_data_o     = words_q;
        state_d         = (flush_pend_q || flush_i) ? S_FLUSH : S_IDLE;
      end
      S_FLUSH: begin
        fill_we_o       = 1'b1;
        fill_way_mask_o = 2'b11;
        fill_index_o    = flush_cnt_q;
        if (flush_cnt_q == {INDEX_W{1'b1}}) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Miss capture, beat/response counters, line assembly, flush bookkeeping
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_q       <= '0;
      way_valid_q  <= 2'b00;
      req_cnt_q    <= 3'd0;
      rsp_cnt_q    <= 3'd0;
      start_q      <= 2'b00;
      words_q      <= '0;
      flush_pend_q <= 1'b0;
      flush_cnt_q  <= '0;
    end else begin
      if (capture) begin
        line_q      <= miss_addr_i[ADDR_W-1:OFFSET_W];
        way_valid_q <= way_valid_i;
        req_cnt_q   <= 3'd0;
        rsp_cnt_q   <= 3'd0;
`ifdef ICACHE_CWF_EN
        start_q     <= miss_addr_i[3:2];
`else
        start_q     <= 2'b00;
`endif
      end
      if (beat_grant) req_cnt_q <= req_cnt_q + 3'd1;
      if (rsp_take) begin
        words_q[rsp_word] <= mem_rdata_i;
        rsp_cnt_q         <= rsp_cnt_q + 3'd1;
      end
      if (state_q == S_FLUSH)                     flush_pend_q <= 1'b0;
      else if (state_q != S_IDLE && flush_i)      flush_pend_q <= 1'b1;
      if (state_q == S_FLUSH) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  // LRU bits: sweep clears, refill write overrides a same-cycle hit to the same set
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lru_q <= '0;
    end else if (state_q == S_FLUSH) begin
      lru_q[flush_cnt_q] <= 1'b0;
    end else begin
      if (hit_valid_i)         lru_q[hit_index_i] <= ~hit_way_i;
      if (state_q == S_WRITE)  lru_q[line_index]  <= ~victim;
    end
  end

endmodule
